spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI responder (slave) for the codebase's SPI master; same CPOL/CPHA mode semantics and MSB-first bit order.
- Oversamples external sclk/csn/mosi in the system clock domain, detects edges, shifts out miso and shifts in mosi.
- Exchanges words with local logic: a tx valid/ready handshake and an rx_valid pulse.
- Supports back-to-back words while csn stays low.

Parameters:
- DATA_WIDTH, 8, bits per word (≥2)
- CPOL, 0, sclk idle level (0: idle low, 1: idle high)
- CPHA, 0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge
- SYNC_STAGES, 2, synchronizer flops on sclk/csn/mosi (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sclk  in  1  SPI clock from master (asynchronous)
- csn  in  1  chip select, active-low (asynchronous)
- mosi  in  1  master-out data (asynchronous)
- miso  out  1  slave-out data
- miso_oe  out  1  miso output enable (high while selected)
- tx_data  in  DATA_WIDTH  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  tx buffer empty, accepts tx_data
- rx_data  out  DATA_WIDTH  last received word
- rx_valid  out  1  one-cycle pulse, rx_data updated
- tx_underrun  out  1  one-cycle pulse, word started with empty tx buffer
- frame_err  out  1  one-cycle pulse, csn rose mid-word

Behaviour:
- Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0, state=IDLE, bit_cnt=0, tx buffer empty. Synchronizer and edge-history flops reset to sclk=CPOL, csn=1.
- Inputs pass through SYNC_STAGES flops plus one history flop. An edge is detected SYNC_STAGES+1 clk cycles after the pin changes.
- Leading edge is the sclk transition away from CPOL; trailing edge is the transition back to CPOL.
- Master timing constraint: sclk half-period ≥ SYNC_STAGES+2 clk. For CPHA=0, csn-fall to first sclk edge ≥ SYNC_STAGES+2 clk.
- Tx buffer: one word. tx_valid&tx_ready loads it and tx_ready drops the next cycle. The buffer empties when its word is moved into the shift register.
- Word load happens at word start: csn-fall detection (CPHA=0, first word), the trailing edge that completes a word (CPHA=0, next word), or the leading edge with bit_cnt=0 (CPHA=1).
  - Buffer full: shift register <= buffer.
  - Buffer empty: shift register <= 0 and tx_underrun pulses.
  - A tx_valid handshake in the same cycle as a word load goes to the buffer; the loaded word is the previous buffer content.
- miso = shift register MSB, registered. miso_oe = 1 in ACTIVE only.
- States:
  - IDLE: on synced csn fall -> ACTIVE; bit_cnt=0; CPHA=0 performs the first word load.
  - ACTIVE: sample edge -> rx shift {rx_sh[DATA_WIDTH-2:0], mosi_sync} and bit_cnt+1. Shift edge -> tx shift left, zero fill.
  - Word completes on the DATA_WIDTH-th sample: the next clk has rx_data <= assembled word and rx_valid=1 for one cycle. bit_cnt wraps to 0.
  - Synced csn rise -> IDLE. If bit_cnt≠0, frame_err pulses and the partial word is discarded (rx_data unchanged).
- Edges seen while in IDLE are ignored.
- csn rise and sample edge detected in the same cycle: csn takes priority; the sample is dropped.
- rst mid-frame returns everything to reset values; a frame in progress is abandoned, with no frame_err and no rx_valid.
- rx_data holds until the next completed word. There is no rx backpressure; a later word overwrites.

Decomposition:
- Shared package spi_pkg: localparam mode encodings, state encoding (IDLE/ACTIVE), and a CPOL/CPHA-to-sample-edge select function. The master reuses these.
- One sub-module: spi_sync_edge, an N-stage synchronizer plus history flop that outputs the synced level, rise and fall. Instanced for sclk and csn; mosi uses the level only.

Test Plan:
- Mode 0, 8-bit, clk/sclk=10, pre-loaded tx 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; tx_ready returns 1.
- Modes 1/2/3, master 0xC3, tx 0x5A -> rx_data=0xC3 and master receives 0x5A in each mode.
- Back-to-back: csn held low 3 words, tx 0x11/0x22/0x33 supplied via handshake, master 0x81/0x42/0x24 -> three rx_valid pulses with matching rx_data; no tx_underrun.
- Empty tx buffer at csn fall -> tx_underrun pulse, master reads 0x00; rx still 0xFF for mosi 0xFF.
- csn rises after 5 bits -> frame_err pulse, no rx_valid, rx_data keeps its previous value, miso_oe=0.
- rst asserted mid-word at bit 3 -> all outputs at reset values next cycle. A following full frame with 0x96 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave:
// mode encodings, FSM state encoding and the sample-edge select helper.
package spi_pkg;

  // Mode number is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // Data is sampled on the rising sclk edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin plus one history flop;
// reports the synchronized level and single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/csn/mosi in the clk domain, shifts MSB-first,
// exchanges words with local logic through a one-word tx buffer and an rx pulse.
//
// Local handshakes: tx_data is accepted on any clk edge where tx_valid && tx_ready;
// tx_valid may only drop after that edge. rx_valid is a one-cycle strobe with no
// backpressure; rx_data holds until the next completed word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output spi_state_t            dbg_state
);

  localparam int              CNT_W       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
  localparam bit              SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic unused_sclk_level, sclk_rise, sclk_fall;
  logic unused_csn_level, csn_rise, csn_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .d(csn),
    .level(unused_csn_level), .rise(csn_rise), .fall(csn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh, buf_q;
  logic [DATA_WIDTH-2:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  buf_full;
  logic                  sample_edge, shift_edge;
  logic                  do_sample, do_shift, word_done, word_load;

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign rx_next     = {rx_sh, mosi_lvl};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A csn rise wins over any sclk edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    word_done = 1'b0;
    word_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csn_fall) begin
          state_d   = ST_ACTIVE;
          word_load = !CPHA;
        end
      end
      ST_ACTIVE: begin
        if (csn_rise) begin
          state_d = ST_IDLE;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
          word_done = sample_edge && (bit_cnt == LAST_BIT);
          // bit_cnt==0 on a shift edge marks a word boundary in both phases
          word_load = shift_edge && (bit_cnt == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      tx_sh       <= '0;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      rx_sh       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      // A handshake coinciding with a load can only happen with the buffer
      // empty, so the load sees the old (empty) buffer and this word waits.
      if (tx_valid && tx_ready) begin
        buf_q    <= tx_data;
        buf_full <= 1'b1;
      end else if (word_load) begin
        buf_full <= 1'b0;
      end

      if (word_load) begin
        if (buf_full) begin
          tx_sh <= buf_q;
        end else begin
          tx_sh       <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      end

      if (do_sample) begin
        rx_sh   <= rx_next[DATA_WIDTH-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end

      if (state_q == ST_ACTIVE && csn_rise) begin
        bit_cnt <= '0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end
    end
  end

  assign tx_ready  = ~buf_full;
  assign miso      = tx_sh[DATA_WIDTH-1];
  assign miso_oe   = (state_q == ST_ACTIVE);
  assign dbg_state = state_q;

endmodule
